// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per request/ack
// handshake, hands instr/pc_out/done_out to decode and applies its redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        done_out,
  output logic [31:0] fetch_count,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RESOLVE = 2'd2,
    S_ERR     = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;
  // Value the wait counter holds during the last tolerated un-acked cycle.
  localparam logic [15:0] TIMEOUT_LAST     = 16'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] wait_q, wait_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        done_q, done_d;
  logic [31:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC_ALIGNED;
      wait_q   <= 16'd0;
      instr_q  <= 32'd0;
      pc_out_q <= 32'd0;
      done_q   <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wait_q   <= wait_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  // Handshake: imem_req is held high with imem_addr stable until an edge
  // sees imem_ack=1; that edge transfers imem_rdata and drops the request.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wait_d   = wait_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    done_d   = 1'b0;
    count_d  = count_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q + 32'd4;
          pc_d     = pc_q + 32'd4;
          done_d   = 1'b1;
          count_d  = count_q + 32'd1;
          wait_d   = 16'd0;
          state_d  = S_RESOLVE;
        end else if (wait_q == TIMEOUT_LAST) begin
          wait_d  = 16'd0;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_RESOLVE: begin
        // Redirect only counts on the edge that leaves RESOLVE.
        if (!stall) begin
          state_d = S_REQ;
          if (redirect) pc_d = redirect_pc & ~32'h3;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign done_out    = done_q;
  assign fetch_count = count_q;
  assign err         = (state_q == S_ERR);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed fetch transactions whose per-cycle outputs
// are predicted from latency/stall/redirect rules and checked every cycle.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          ACK_TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        done_out;
  logic [31:0] fetch_count;
  logic        err;
  logic [1:0]  dbg_state;

  instr_fetch #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .pc_out(pc_out), .done_out(done_out),
    .fetch_count(fetch_count), .err(err), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        done;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // transaction-level model state
  logic [31:0] m_pc, m_instr, m_pc_out, m_count;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snap(input logic req, input logic done);
    exp_t e;
    e.req    = req;
    e.addr   = m_pc;
    e.done   = done;
    e.instr  = m_instr;
    e.pc_out = m_pc_out;
    e.cnt    = m_count;
    e.err    = m_err;
    return e;
  endfunction

  // scoreboard: one expected entry per cycle, compared away from the edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      if (e.req) check("imem_addr", imem_addr, e.addr);
      check("done_out", {31'd0, done_out}, {31'd0, e.done});
      check("instr", instr, e.instr);
      check("pc_out", pc_out, e.pc_out);
      check("fetch_count", fetch_count, e.cnt);
      check("err", {31'd0, err}, {31'd0, e.err});
    end
  end

  // driver tasks
  task automatic step(input logic a, input logic [31:0] d, input logic st,
                      input logic rd, input logic [31:0] rpc, input exp_t e);
    @(posedge clk);
    #1;
    imem_ack    = a;
    imem_rdata  = d;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic ack_during);
    rst = 1'b0;
    exp_q.delete();
    m_pc     = RESET_PC & ~32'h3;
    m_instr  = 32'd0;
    m_pc_out = 32'd0;
    m_count  = 32'd0;
    m_err    = 1'b0;
    for (int i = 0; i < 2; i++) step(ack_during, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, snap(1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst      = 1'b1;
    imem_ack = 1'b0;
    exp_q.push_back(snap(1'b0, 1'b0));
  endtask

  // One instruction: lat un-acked REQ cycles, ack, then stl stall cycles in
  // RESOLVE; noise drives redirect where it must be ignored.
  task automatic fetch(input int lat, input int stl, input logic [31:0] word,
                       input logic rd, input logic [31:0] tgt, input logic noise);
    for (int i = 0; i <= lat; i++)
      step(i == lat, (i == lat) ? word : ~word, 1'b0, noise, 32'hDEAD_BEE0, snap(1'b1, 1'b0));
    m_instr  = word;
    m_pc_out = m_pc + 32'd4;
    m_pc     = m_pc + 32'd4;
    m_count  = m_count + 32'd1;
    for (int j = 0; j <= stl; j++)
      step(1'b0, 32'd0, j < stl, (j < stl) ? noise : rd,
           (j < stl) ? 32'hBAD0_0000 : tgt, snap(1'b0, j == 0));
    if (rd) m_pc = tgt & ~32'h3;
  endtask

  initial begin
    rst         = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;

    do_reset(1'b0);

    // sequential fetch at 0,4,8; third exit jumps to 0x40
    fetch(0, 0, 32'h1111_0001, 1'b0, 32'd0, 1'b0);
    fetch(0, 0, 32'h1111_0002, 1'b0, 32'd0, 1'b0);
    fetch(0, 0, 32'h1111_0003, 1'b1, 32'h0000_0042, 1'b0);
    check("seq_count", fetch_count, 32'd3);
    check("seq_pc_out", pc_out, 32'd12);
    check("model_count", m_count, 32'd3);

    // latency 3 at 0x40, ack lands in the last tolerated cycle
    fetch(3, 0, 32'h2108_000A, 1'b1, 32'h0000_1003, 1'b1);
    check("lat_instr", instr, 32'h2108_000A);
    check("lat_pc_out", pc_out, 32'h0000_0044);
    check("lat_no_err", {31'd0, err}, 32'd0);

    // landed on the redirect target
    fetch(0, 0, 32'h3333_0000, 1'b0, 32'd0, 1'b0);
    check("jump_pc_out", pc_out, 32'h0000_1004);

    // three stall cycles with redirect noise, real redirect as stall falls
    fetch(1, 3, 32'h4444_0000, 1'b1, 32'h0000_2000, 1'b1);
    check("stall_instr", instr, 32'h4444_0000);

    // wrap: jump to 0xFFFF_FFFC, fetch there, then sequential to 0
    fetch(2, 0, 32'h5555_0000, 1'b1, 32'hFFFF_FFFF, 1'b0);
    fetch(0, 0, 32'h6666_0000, 1'b0, 32'd0, 1'b0);
    check("wrap_pc_out", pc_out, 32'd0);
    fetch(0, 0, 32'h7777_0000, 1'b0, 32'd0, 1'b0);
    check("wrap_count", fetch_count, 32'd9);

    // async reset in the middle of a REQ cycle
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, snap(1'b1, 1'b0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_done", {31'd0, done_out}, 32'd0);
    check("arst_instr", instr, 32'd0);
    check("arst_pc_out", pc_out, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    imem_ack = 1'b1;
    do_reset(1'b1);

    // timeout: four un-acked REQ cycles, then ERR holds despite ack
    for (int i = 0; i < ACK_TIMEOUT; i++)
      step(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0100, snap(1'b1, 1'b0));
    m_err = 1'b1;
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0, snap(1'b0, 1'b0));
    check("err_sticky", {31'd0, err}, 32'd1);
    check("err_count", fetch_count, 32'd0);

    do_reset(1'b0);
    @(negedge clk);
    check("err_cleared", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
